carpbol_denetleyici: RTL and testbench

CARPBOL_DENETLEYICI -- requirements
Module: carpbol_denetleyici

---
 rtl/carpbol_denetleyici.sv | 148 ++++++++++++++
 tb/tb_carpbol_denetleyici.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/carpbol_denetleyici.sv
// RV32 M-extension multiply/divide unit: iterative shift-add multiply and
// restoring divide, 32 iterations per operation, with optional fast exit.
module carpbol_denetleyici #(
    parameter int unsigned HIZLI_YOL = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        basla_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] islenen1_i,
    input  logic [31:0] islenen2_i,
    input  logic        iptal_i,
    output logic [31:0] sonuc_o,
    output logic        gecerli_o,
    output logic        mesgul_o,
    output logic        durdur_o
);

    typedef enum logic [2:0] {
        BOSTA, HAZIRLA, HESAPLA, DUZELT, BITTI
    } durum_t;

    durum_t      durum;
    logic [5:0]  sayac;
    logic [2:0]  islem_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [31:0] ikinci_q;
    logic [63:0] ara_q;
    logic        isaret_q;
    logic        kalan_isaret_q;

    logic        bolme;
    logic        isaretli1;
    logic        isaretli2;
    logic        neg1;
    logic        neg2;
    logic [31:0] mutlak1;
    logic [31:0] mutlak2;
    logic        bolen_sifir;
    logic        tasma;
    logic [31:0] hizli_sonuc;
    logic [32:0] carp_toplam;
    logic [33:0] deneme;
    logic [63:0] ara_sonraki;
    logic [63:0] carpim;
    logic [31:0] bolum;
    logic [31:0] kalan;
    logic [31:0] duz_sonuc;

    always_comb begin
        bolme       = islem_q[2];
        isaretli1   = (islem_q == 3'b000) || (islem_q == 3'b001) || (islem_q == 3'b010)
                   || (islem_q == 3'b100) || (islem_q == 3'b110);
        isaretli2   = (islem_q == 3'b000) || (islem_q == 3'b001)
                   || (islem_q == 3'b100) || (islem_q == 3'b110);
        neg1        = isaretli1 && op1_q[31];
        neg2        = isaretli2 && op2_q[31];
        mutlak1     = neg1 ? (32'd0 - op1_q) : op1_q;
        mutlak2     = neg2 ? (32'd0 - op2_q) : op2_q;
        bolen_sifir = (op2_q == '0);
        tasma       = bolme && isaretli2 && (op1_q == 32'h8000_0000) && (op2_q == '1);
        if (bolen_sifir)
            hizli_sonuc = islem_q[1] ? op1_q : '1;
        else
            hizli_sonuc = islem_q[1] ? '0 : 32'h8000_0000;

        // Multiply: product upper half accumulates, rs2 bits consumed from the LSB.
        // Divide: {remainder, dividend} shifts left, quotient bits enter at the LSB.
        carp_toplam = {1'b0, ara_q[63:32]} + (ara_q[0] ? {1'b0, ikinci_q} : 33'd0);
        deneme      = {1'b0, ara_q[63:31]} - {2'b00, ikinci_q};
        if (!bolme)
            ara_sonraki = {carp_toplam, ara_q[31:1]};
        else if (!deneme[33])
            ara_sonraki = {deneme[31:0], ara_q[30:0], 1'b1};
        else
            ara_sonraki = {ara_q[62:0], 1'b0};

        carpim = isaret_q ? (64'd0 - ara_q) : ara_q;
        bolum  = isaret_q ? (32'd0 - ara_q[31:0]) : ara_q[31:0];
        kalan  = kalan_isaret_q ? (32'd0 - ara_q[63:32]) : ara_q[63:32];
        if (!bolme)
            duz_sonuc = (islem_q[1:0] == 2'b00) ? carpim[31:0] : carpim[63:32];
        else
            duz_sonuc = islem_q[1] ? kalan : bolum;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum          <= BOSTA;
            sayac          <= '0;
            islem_q        <= '0;
            op1_q          <= '0;
            op2_q          <= '0;
            ikinci_q       <= '0;
            ara_q          <= '0;
            isaret_q       <= 1'b0;
            kalan_isaret_q <= 1'b0;
            sonuc_o        <= '0;
        end else if (durum == BOSTA) begin
            if (basla_i && !iptal_i) begin
                islem_q <= funct3_i;
                op1_q   <= islenen1_i;
                op2_q   <= islenen2_i;
                durum   <= HAZIRLA;
            end
        end else if (iptal_i) begin
            durum <= BOSTA;
            sayac <= '0;
        end else begin
            case (durum)
                HAZIRLA: begin
                    // A zero divisor keeps the quotient all-ones, so its sign is never applied.
                    isaret_q       <= (bolme && bolen_sifir) ? 1'b0 : (neg1 ^ neg2);
                    kalan_isaret_q <= neg1;
                    if ((HIZLI_YOL != 0) && bolme && (bolen_sifir || tasma)) begin
                        sonuc_o <= hizli_sonuc;
                        durum   <= BITTI;
                    end else begin
                        ara_q    <= bolme ? {32'd0, mutlak1} : {32'd0, mutlak2};
                        ikinci_q <= bolme ? mutlak2 : mutlak1;
                        sayac    <= '0;
                        durum    <= HESAPLA;
                    end
                end
                HESAPLA: begin
                    ara_q <= ara_sonraki;
                    sayac <= sayac + 6'd1;
                    if (sayac == 6'd31)
                        durum <= DUZELT;
                end
                DUZELT: begin
                    sonuc_o <= duz_sonuc;
                    durum   <= BITTI;
                end
                default: durum <= BOSTA;
            endcase
        end
    end

    // The valid pulse must be squashable by a flush in the same cycle, so it is
    // decoded from the state rather than registered separately.
    assign gecerli_o = (durum == BITTI) && !iptal_i;
    assign mesgul_o  = (durum != BOSTA);
    assign durdur_o  = ((durum == BOSTA) && basla_i && !iptal_i)
                    || (durum == HAZIRLA) || (durum == HESAPLA) || (durum == DUZELT);

endmodule

// File: tb/tb_carpbol_denetleyici.sv
// Directed bench for carpbol_denetleyici: fast-path and full-iteration
// instances run the same vectors side by side.
module tb_carpbol_denetleyici;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        basla;
    logic [2:0]  funct3;
    logic [31:0] is1;
    logic [31:0] is2;
    logic        iptal;
    logic [31:0] sonuc_h, sonuc_y;
    logic        gecerli_h, gecerli_y;
    logic        mesgul_h, mesgul_y;
    logic        durdur_h, durdur_y;

    int kontrol_sayisi = 0;
    int hata_sayisi    = 0;

    always #5 clk = ~clk;

    carpbol_denetleyici #(.HIZLI_YOL(1)) u_hizli (
        .clk_i(clk), .rst_ni(rst_n), .basla_i(basla), .funct3_i(funct3),
        .islenen1_i(is1), .islenen2_i(is2), .iptal_i(iptal),
        .sonuc_o(sonuc_h), .gecerli_o(gecerli_h), .mesgul_o(mesgul_h), .durdur_o(durdur_h)
    );

    carpbol_denetleyici #(.HIZLI_YOL(0)) u_yavas (
        .clk_i(clk), .rst_ni(rst_n), .basla_i(basla), .funct3_i(funct3),
        .islenen1_i(is1), .islenen2_i(is2), .iptal_i(iptal),
        .sonuc_o(sonuc_y), .gecerli_o(gecerli_y), .mesgul_o(mesgul_y), .durdur_o(durdur_y)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        bit          hizli;
        bit          iptal_bitti;
    } vektor_t;

    localparam int N = 19;
    vektor_t tablo[N];

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gercek !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge of
    // cycle T+36, so consecutive calls exercise back-to-back requests.
    task automatic calistir(input vektor_t v, input int idx);
        int ilk_h, ilk_y, adet_h, adet_y, durdur_hata, lat_h, bek_ilk_h, bek_ilk_y;
        lat_h = v.hizli ? 2 : 35;
        bek_ilk_y = v.iptal_bitti ? 0 : 35;
        bek_ilk_h = (v.iptal_bitti && !v.hizli) ? 0 : lat_h;
        basla = 1'b1; funct3 = v.f; is1 = v.a; is2 = v.b;
        #1;
        kontrol($sformatf("v%0d durdur_T", idx), {30'd0, durdur_h, durdur_y}, 32'd3);
        ilk_h = 0; ilk_y = 0; adet_h = 0; adet_y = 0; durdur_hata = 0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            basla = 1'b0;
            if (v.iptal_bitti && k == 35) iptal = 1'b1;
            if (k == 36) iptal = 1'b0;
            #1;
            if (gecerli_h) begin adet_h++; if (ilk_h == 0) ilk_h = k; end
            if (gecerli_y) begin adet_y++; if (ilk_y == 0) ilk_y = k; end
            if (durdur_y !== (k < 35)) durdur_hata++;
            if (mesgul_y !== (k <= 35)) durdur_hata++;
            if (durdur_h !== (k < lat_h)) durdur_hata++;
            if (mesgul_h !== (k <= lat_h)) durdur_hata++;
        end
        kontrol($sformatf("v%0d sonuc_hizli", idx), sonuc_h, v.s);
        kontrol($sformatf("v%0d sonuc_yavas", idx), sonuc_y, v.s);
        kontrol($sformatf("v%0d gecerli_cevrim_hizli", idx), ilk_h, bek_ilk_h);
        kontrol($sformatf("v%0d gecerli_cevrim_yavas", idx), ilk_y, bek_ilk_y);
        kontrol($sformatf("v%0d gecerli_adet_hizli", idx), adet_h, (bek_ilk_h == 0) ? 0 : 1);
        kontrol($sformatf("v%0d gecerli_adet_yavas", idx), adet_y, (bek_ilk_y == 0) ? 0 : 1);
        kontrol($sformatf("v%0d durdur_mesgul_hata", idx), durdur_hata, 0);
    endtask

    initial begin
        int adet;
        logic [31:0] onceki;

        tablo[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0};
        tablo[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0};
        tablo[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tablo[3]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0};
        tablo[4]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0};
        tablo[5]  = '{3'b101, 32'd100,        32'd7,         32'd14,        1'b0, 1'b0};
        tablo[6]  = '{3'b111, 32'd100,        32'd7,         32'd2,         1'b0, 1'b0};
        tablo[7]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0};
        tablo[8]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0};
        tablo[9]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0};
        tablo[10] = '{3'b111, 32'd7,          32'd0,         32'd7,         1'b1, 1'b0};
        tablo[11] = '{3'b100, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0};
        tablo[12] = '{3'b110, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1'b1, 1'b0};
        tablo[13] = '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0};
        tablo[14] = '{3'b000, 32'h1234_5678,  32'h10,        32'h2345_6780, 1'b0, 1'b0};
        tablo[15] = '{3'b011, 32'h8000_0000,  32'd4,         32'd2,         1'b0, 1'b0};
        tablo[16] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0, 1'b0};
        tablo[17] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0};
        tablo[18] = '{3'b111, 32'd100,        32'd9,         32'd1,         1'b0, 1'b1};

        rst_n = 1'b0; basla = 1'b0; funct3 = '0; is1 = '0; is2 = '0; iptal = 1'b0;
        #3;
        kontrol("reset_sonuc", {sonuc_h ^ sonuc_y} | sonuc_h, 32'd0);
        kontrol("reset_bayrak", {28'd0, gecerli_h, gecerli_y, mesgul_h | mesgul_y, durdur_h | durdur_y}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < N; i++) calistir(tablo[i], i);

        // Flush during HESAPLA of a signed divide.
        onceki = tablo[N-1].s;
        basla = 1'b1; funct3 = 3'b100; is1 = 32'd100; is2 = 32'd7;
        adet = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            basla = 1'b0;
            if (k == 10) iptal = 1'b1;
            if (k == 11) iptal = 1'b0;
            #1;
            if (gecerli_h || gecerli_y) adet++;
            if (k == 11) kontrol("iptal_mesgul", {30'd0, mesgul_h, mesgul_y}, 32'd0);
        end
        kontrol("iptal_gecerli_yok", adet, 0);
        kontrol("iptal_sonuc_hizli", sonuc_h, onceki);
        kontrol("iptal_sonuc_yavas", sonuc_y, onceki);

        // Request together with flush in BOSTA is not accepted.
        basla = 1'b1; iptal = 1'b1;
        #1;
        kontrol("red_durdur", {30'd0, durdur_h, durdur_y}, 32'd0);
        @(negedge clk);
        basla = 1'b0; iptal = 1'b0;
        #1;
        kontrol("red_mesgul", {30'd0, mesgul_h, mesgul_y}, 32'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of a multiply.
        basla = 1'b1; funct3 = 3'b000; is1 = 32'h1234_5678; is2 = 32'd3;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            basla = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        kontrol("rst_sonuc_hizli", sonuc_h, 32'd0);
        kontrol("rst_sonuc_yavas", sonuc_y, 32'd0);
        kontrol("rst_bayrak", {26'd0, gecerli_h, gecerli_y, mesgul_h, mesgul_y, durdur_h, durdur_y}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        adet = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #1;
            if (gecerli_h || gecerli_y || mesgul_h || mesgul_y) adet++;
        end
        kontrol("rst_sonrasi_sessiz", adet, 0);
        calistir('{3'b000, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0}, N);

        $display("== %0d vectors applied, %0d miscompares ==", kontrol_sayisi, hata_sayisi);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL zaman_asimi: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
